led_feed: RTL and testbench

- Pattern source for the 16-LED shifting display.
- The display shifter raises a read-in request (readin_en) when its bottom two LEDs are both lit. led_feed answers each request with the next 16-bit pattern through a valid/ready handshake.
- Patterns come from an internal 16-bit Galois LFSR and are pre-buffered in a small FIFO so a request is served without generation stalls.
- A programmable round length ends the sequence with a done flag.

---
 rtl/led_feed_pkg.sv | 9 +
 rtl/led_feed_fifo.sv | 43 ++++
 rtl/led_feed.sv | 102 ++++++++++
 tb/tb_led_feed.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_feed_pkg.sv
// led_feed_pkg: shared FSM state type and LFSR defaults for the LED pattern feed
package led_feed_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/led_feed_fifo.sv
// led_feed_fifo: synchronous prefetch FIFO; push on full is accepted only alongside a pop
module led_feed_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push & (~full | pop);
    do_pop = pop & ~empty;
    head = mem_q[rp_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/led_feed.sv
// led_feed: LFSR pattern source answering display read-in requests over valid/ready
module led_feed
  import led_feed_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] SEED = LFSR_SEED,
  parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             readin_en,
  input  logic             start,
  input  logic [7:0]       round_len,
  input  logic             pat_ready,
  output logic             pat_valid,
  output logic [WIDTH-1:0] pat_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       served
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, data_q, data_d, head;
  logic [8:0] len_q, len_d, gen_q, gen_d, acc_q, acc_d;
  logic [7:0] served_q, served_d;
  logic req_q, pend_q, pend_d, valid_q, valid_d, done_q;
  logic full, empty, ev, begin_round, acc, last, gen, load;
  logic [CW-1:0] count;
  led_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(last),
    .push(gen),
    .din(lfsr_q),
    .pop(acc),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? FILL : IDLE;
      FILL: state_d = last ? IDLE : (full | gen_q == len_q) ? RUN : FILL;
      RUN:  state_d = last ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb busy = state_q != IDLE;
  always_comb begin
    ev = readin_en & ~req_q;
    begin_round = start & (state_q == IDLE);
    acc = valid_q & pat_ready;
    last = acc & (acc_q + 9'd1 == len_q);
    // a push into a full FIFO is only legal when the same cycle pops
    gen = busy & ~last & (gen_q < len_q) & ((count < CW'(DEPTH)) | acc);
    load = busy & pend_q & ~empty & ~valid_q;
    len_d = begin_round ? {round_len == 8'd0, round_len} : len_q;
    gen_d = begin_round ? 9'd0 : gen_q + 9'(gen);
    acc_d = begin_round ? 9'd0 : acc_q + 9'(acc);
    served_d = begin_round ? 8'd0 : (acc & ~&served_q) ? served_q + 8'd1 : served_q;
    pend_d = busy & ~acc & (pend_q | ev);
    valid_d = load | (valid_q & ~acc);
    data_d = load ? head : data_q;
    lfsr_d = gen ? (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0) : lfsr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      data_q <= '0;
      len_q <= '0;
      gen_q <= '0;
      acc_q <= '0;
      served_q <= '0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      len_q <= len_d;
      gen_q <= gen_d;
      acc_q <= acc_d;
      served_q <= served_d;
      req_q <= readin_en;
      pend_q <= pend_d;
      valid_q <= valid_d;
      done_q <= last;
    end
  end
  always_comb begin
    pat_valid = valid_q;
    pat_data = data_q;
    done = done_q;
    served = served_q;
  end
endmodule

// File: tb/tb_led_feed.sv
// tb_led_feed: scoreboard bench for led_feed; expected patterns come from a bench-side LFSR model
module tb_led_feed;
  logic clk = 1'b0;
  logic rst, readin_en, start, pat_ready;
  logic [7:0] round_len;
  logic pat_valid, busy, done;
  logic [15:0] pat_data;
  logic [7:0] served;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] done_served = 8'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] sb_q[$];

  led_feed dut (
    .clk(clk),
    .rst(rst),
    .readin_en(readin_en),
    .start(start),
    .round_len(round_len),
    .pat_ready(pat_ready),
    .pat_valid(pat_valid),
    .pat_data(pat_data),
    .busy(busy),
    .done(done),
    .served(served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pat();
    sb_q.push_back(m_lfsr);
    m_lfsr = model_next(m_lfsr);
  endtask

  task automatic begin_round(input logic [7:0] len);
    round_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic take(input bit lat_chk);
    int n;
    expect_pat();
    readin_en = 1'b1;
    tick();
    readin_en = 1'b0;
    n = 1;
    while (!pat_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_seen", pat_valid, 1);
    if (lat_chk) check("latency", n, 2);
    pat_ready = 1'b1;
    tick();
    pat_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_served = served;
    end
    if (pat_valid && pat_ready && !rst) begin
      acc_cnt++;
      if (sb_q.size() == 0) check("sb_underrun", 1, 0);
      else check("pat_data", pat_data, sb_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, a0;
    bit stable;
    logic [15:0] held;
    rst = 1'b1;
    readin_en = 1'b0;
    start = 1'b0;
    pat_ready = 1'b0;
    round_len = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", pat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_served", served, 0);
    check("rst_data", pat_data, 0);

    // round of 3: first pattern is the seed, then its successors
    begin_round(8'd3);
    check("r3_busy", busy, 1);
    d0 = done_cnt;
    take(1);
    check("r3_served1", served, 1);
    check("r3_done_early1", done, 0);
    take(1);
    check("r3_served2", served, 2);
    take(1);
    check("r3_served3", served, 3);
    check("r3_done", done, 1);
    check("r3_busy_end", busy, 0);
    tick();
    check("r3_done_pulse", done, 0);
    check("r3_done_once", done_cnt - d0, 1);

    // held request with consumer stalled; second edge while pending is absorbed
    begin_round(8'd5);
    expect_pat();
    readin_en = 1'b1;
    stable = 1'b1;
    held = 16'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pat_valid && held == 16'h0) held = pat_data;
      else if (pat_valid && pat_data != held) stable = 1'b0;
    end
    check("hold_valid", pat_valid, 1);
    check("hold_stable", stable, 1);
    check("hold_data", pat_data, sb_q[0]);
    check("hold_served", served, 0);
    readin_en = 1'b0;
    tick();
    readin_en = 1'b1;
    tick();
    readin_en = 1'b0;
    tick();
    check("hold2_valid", pat_valid, 1);
    check("hold2_served", served, 0);
    pat_ready = 1'b1;
    tick();
    pat_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("absorb_novalid", pat_valid, 0);
    check("absorb_served", served, 1);
    for (int i = 0; i < 4; i++) take(0);
    check("r5_served", served, 5);
    check("r5_done", done, 1);

    // 256-pattern round with the consumer always ready
    begin_round(8'd0);
    d0 = done_cnt;
    a0 = acc_cnt;
    pat_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      expect_pat();
      readin_en = 1'b1;
      tick();
      readin_en = 1'b0;
      tick();
      tick();
      tick();
      if (i == 254) begin
        check("r256_sat_pre", served, 255);
        check("r256_no_early_done", done_cnt - d0, 0);
        check("r256_busy", busy, 1);
      end
    end
    pat_ready = 1'b0;
    check("r256_accepts", acc_cnt - a0, 256);
    check("r256_done_once", done_cnt - d0, 1);
    check("r256_done_served", done_served, 255);
    check("r256_served", served, 255);
    check("r256_busy_end", busy, 0);

    // reset mid-round with a pattern on offer
    begin_round(8'd4);
    take(0);
    check("mid_served", served, 1);
    expect_pat();
    readin_en = 1'b1;
    tick();
    readin_en = 1'b0;
    for (int i = 0; i < 20 && !pat_valid; i++) tick();
    check("mid_valid", pat_valid, 1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", pat_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_served", served, 0);
    check("mrst_done", done, 0);
    sb_q.delete();
    m_lfsr = 16'hACE1;
    tick();
    check("mrst_no_done", done_cnt - d0, 0);

    // requests while idle are ignored
    for (int i = 0; i < 3; i++) begin
      readin_en = 1'b1;
      tick();
      readin_en = 1'b0;
      tick();
    end
    tick();
    tick();
    check("idle_valid", pat_valid, 0);
    check("idle_busy", busy, 0);

    // start while busy is ignored; seed restored after reset
    d0 = done_cnt;
    begin_round(8'd2);
    round_len = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    take(1);
    take(0);
    check("rb_done", done, 1);
    check("rb_served", served, 2);
    tick();
    check("rb_busy", busy, 0);
    check("rb_done_once", done_cnt - d0, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
